mult_div_unit: RTL and testbench

- Iterative multiply/divide unit beside the ALU in the EX stage; executes MULT, MULTU, DIV and DIVU on the same rs/rt operands the ALU receives.
- Owns the HI and LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.
- Uses a start/busy/done handshake; the controller stalls while busy is high.
- Uses one shift-add or restoring-division step per cycle, so the fixed latency is WIDTH cycles plus one.

---
 rtl/mult_div_unit.sv | 125 ++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or restoring-divide step per cycle.
// busy is high for WIDTH cycles after the accept cycle and done pulses the cycle after; start is ignored while iterating.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg1, neg2;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     madd, dtrial;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    abs1 = (!op[0] && in1[WIDTH-1]) ? -in1 : in1;
    abs2 = (!op[0] && in2[WIDTH-1]) ? -in2 : in2;

    // Multiply: acc_lo holds the shrinking multiplier, acc_hi the partial sum.
    // Divide: acc_lo shifts the dividend out and quotient bits in, acc_hi is the remainder.
    madd   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a} : '0);
    dtrial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, b};
    if (is_div) begin
      nxt_hi = dtrial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : dtrial[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~dtrial[WIDTH]};
    end else begin
      nxt_hi = madd[WIDTH:1];
      nxt_lo = {madd[0], acc_lo[WIDTH-1:1]};
    end

    prod = {nxt_hi, nxt_lo};
    if (neg1 ^ neg2) prod = -prod;

    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b == '0) begin
      res_hi = neg1 ? -a : a;
      res_lo = '1;
    end else begin
      res_hi = neg1 ? -nxt_hi : nxt_hi;
      res_lo = (neg1 ^ neg2) ? -nxt_lo : nxt_lo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      a      <= '0;
      b      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      busy <= (state == CALC);
      done <= (state == DONE);

      // busy trails state by one cycle, so gating on both blocks writes for the whole busy window.
      if (state != CALC && !busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= op[1];
            neg1   <= !op[0] && in1[WIDTH-1];
            neg2   <= !op[0] && in2[WIDTH-1];
            a      <= abs1;
            b      <= abs2;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs1 : abs2;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, hand-written corner sequences, and random ops against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] in1, in2, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] in1, in2, ehi, elo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    sx = x;
    sy = y;
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin sp = longint'(sx) * longint'(sy); up = sp; eh = up[63:32]; el = up[31:0]; end
      2'd1: begin up = {32'b0, x} * {32'b0, y}; eh = up[63:32]; el = up[31:0]; end
      2'd2: begin
        if (y == 0) begin eh = x; el = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin eh = '0; el = x; end
        else begin el = sx / sy; eh = sx % sy; end
      end
      default: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; in1 = x; in2 = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op  = 2'($urandom);
    in1 = $urandom;
    in2 = $urandom;
  endtask

  // Samples at negedges after the accept edge; optionally pokes start+MTHI at cycle poke.
  task automatic wait_done(input string name, input int poke);
    int at = -1;
    int nbusy = 0;
    logic [W-1:0] hi0 = '0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      if (j == 0) hi0 = hi;
      if (poke >= 0 && j == poke + 1) check({name, "_hi_during_calc"}, hi, hi0);
      if (busy) nbusy++;
      if (done) begin at = j; break; end
      if (j == poke) begin
        start = 1'b1; op = 2'd1; in1 = 2; in2 = 2; hi_we = 1'b1; wdata = 32'hAA;
      end
    end
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(W));
    check({name, "_done_cycle"}, 32'(at), 32'(W + 1));
  endtask

  initial begin
    logic [W-1:0] eh, el, prev;
    int ndone;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'h8000_0005, 32'd0,         32'h8000_0005, 32'hFFFF_FFFF};
    vecs[6] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].op, vecs[i].in1, vecs[i].in2);
      wait_done($sformatf("vec%0d", i), -1);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(done), 0);
      check($sformatf("vec%0d_hi_hold", i), hi, vecs[i].ehi);
    end

    // MULT then DIV accepted straight out of the done cycle.
    start_op(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("b2b_mult", -1);
    check("b2b_mult_hi", hi, 32'hFFFF_FFFF);
    check("b2b_mult_lo", lo, 32'hFFFF_FFF1);
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("b2b_div", -1);
    check("b2b_div_hi", hi, 32'hFFFF_FFFF);
    check("b2b_div_lo", lo, 32'hFFFF_FFFD);

    // Start and MTHI during CALC are both dropped.
    start_op(2'd3, 32'd100, 32'd7);
    wait_done("ignore", 4);
    check("ignore_hi", hi, 32'd2);
    check("ignore_lo", lo, 32'd14);
    @(negedge clk);
    check("ignore_no_restart", 32'(busy), 0);

    // Write strobes coinciding with start: written now, overwritten by the result.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
    start_op(2'd1, 32'd3, 32'd4);
    hi_we = 1'b0; lo_we = 1'b0;
    check("coinc_hi_written", hi, 32'h5555);
    check("coinc_lo_written", lo, 32'h5555);
    wait_done("coinc", -1);
    check("coinc_hi", hi, 32'd0);
    check("coinc_lo", lo, 32'd12);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 7 == 3) ry = '0;
      if (i % 5 == 1) ry = ry >> $urandom_range(0, 31);
      if (i % 9 == 2) rx = 32'h8000_0000;
      model(ro, rx, ry, eh, el);
      start_op(ro, rx, ry);
      wait_done($sformatf("rand%0d", i), -1);
      check($sformatf("rand%0d_op%0d_%h_%h_hi", i, ro, rx, ry), hi, eh);
      check($sformatf("rand%0d_op%0d_%h_%h_lo", i, ro, rx, ry), lo, el);
    end

    // MTHI then MTLO in idle.
    @(negedge clk);
    prev = lo;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_unchanged", lo, prev);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_unchanged", hi, 32'h1234);

    // Reset mid-operation clears everything and no done follows.
    @(negedge clk);
    start_op(2'd1, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #2;
    check("midrst_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 0);
    check("midrst_hi_after", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
